// File: rtl/viterbi_pkg.sv
// Shared types and defaults for the Viterbi frame sequencer.
package viterbi_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam int CODE_K        = 3;
    localparam int DEF_TAIL_LEN  = CODE_K - 1;
    localparam int DEF_TB_DEPTH  = 10;
    localparam int DEF_FRAME_LEN = 64;
    localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/viterbi_frame_ctrl_if.sv
// Control, symbol source, core and bit sink signals of the frame sequencer.
interface viterbi_frame_ctrl_if;
    logic       start;
    logic       busy;
    logic       s_valid;
    logic [1:0] s_sym;
    logic       s_ready;
    logic       dec_clr;
    logic       dec_en;
    logic [1:0] dec_sym;
    logic       dec_bit;
    logic       m_valid;
    logic       m_bit;
    logic       m_last;
    logic       m_ready;
    logic       frame_done;

    // master: the sequencer itself
    modport master (
        input  start, s_valid, s_sym, dec_bit, m_ready,
        output busy, s_ready, dec_clr, dec_en, dec_sym, m_valid, m_bit, m_last, frame_done
    );

    // slave: symbol source, decode core and bit sink around it
    modport slave (
        output start, s_valid, s_sym, dec_bit, m_ready,
        input  busy, s_ready, dec_clr, dec_en, dec_sym, m_valid, m_bit, m_last, frame_done
    );
endinterface

// File: rtl/vit_out_stage.sv
// Output stage: registered m_valid/m_last, stall, and decode of which steps
// yield an info bit (step k carries symbol j = k-(TB_DEPTH-1)).
module vit_out_stage
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int TAIL_LEN  = DEF_TAIL_LEN,
    parameter int TB_DEPTH  = DEF_TB_DEPTH,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_i,
    input  logic [CNT_W-1:0] step_cnt_i,   // count before this step
    input  logic             m_ready_i,
    output logic             m_valid_o,
    output logic             m_last_o,
    output logic             stall_o
);
    // step_cnt_i+1 is the step number k; productive when 1 <= k-(TB_DEPTH-1) <= FRAME_LEN-TAIL_LEN
    localparam logic [CNT_W-1:0] FIRST_CNT = CNT_W'(TB_DEPTH - 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_LEN - TAIL_LEN + TB_DEPTH - 2);

    logic m_valid_q, m_valid_d;
    logic m_last_q, m_last_d;
    logic prod;

    assign stall_o   = m_valid_q & ~m_ready_i;
    assign prod      = step_i && (step_cnt_i >= FIRST_CNT) && (step_cnt_i <= LAST_CNT);
    assign m_valid_o = m_valid_q;
    assign m_last_o  = m_last_q;

    // New bit replaces the old one on a productive step; otherwise drop it once taken
    always_comb begin
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        if (prod) begin
            m_valid_d = 1'b1;
            m_last_d  = (step_cnt_i == LAST_CNT);
        end else if (m_ready_i) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end
    end

    // Output flags register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end
endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the rate-1/2 K=3 Viterbi core: clear, run, flush, emit bits.
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int TAIL_LEN  = DEF_TAIL_LEN,
    parameter int TB_DEPTH  = DEF_TB_DEPTH,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    viterbi_frame_ctrl_if.master bus
);
    localparam logic [CNT_W-1:0] LAST_SYM_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] MAX_STEPS    = CNT_W'(FRAME_LEN + TB_DEPTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic             step, stall, frame_end;
    logic             m_valid, m_last;
    logic             busy, s_ready, dec_clr, frame_done;
    logic [1:0]       dec_sym;

    vit_out_stage #(
        .FRAME_LEN (FRAME_LEN),
        .TAIL_LEN  (TAIL_LEN),
        .TB_DEPTH  (TB_DEPTH),
        .CNT_W     (CNT_W)
    ) u_out (
        .clk        (clk),
        .rst        (rst),
        .step_i     (step),
        .step_cnt_i (step_cnt_q),
        .m_ready_i  (bus.m_ready),
        .m_valid_o  (m_valid),
        .m_last_o   (m_last),
        .stall_o    (stall)
    );

    assign frame_end = (state_q == FLUSH) & m_valid & bus.m_ready & m_last;

    // State and step counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    // Next state: frame ends on acceptance of the last info bit, not on step count
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CLEAR;
            CLEAR:   state_d = RUN;
            RUN:     if (step && step_cnt_q == LAST_SYM_CNT) state_d = FLUSH;
            FLUSH:   if (frame_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Step counter restarts from zero for every frame
    always_comb begin
        step_cnt_d = step_cnt_q;
        if (state_q == IDLE || state_q == CLEAR) step_cnt_d = '0;
        else if (step)                           step_cnt_d = step_cnt_q + 1'b1;
    end

    // Outputs: core only steps when the held output bit is not blocked
    always_comb begin
        busy       = 1'b0;
        s_ready    = 1'b0;
        dec_clr    = 1'b0;
        step       = 1'b0;
        dec_sym    = 2'b00;
        frame_done = 1'b0;
        case (state_q)
            CLEAR: begin
                busy    = 1'b1;
                dec_clr = 1'b1;
            end
            RUN: begin
                busy    = 1'b1;
                s_ready = ~stall;
                step    = bus.s_valid & ~stall;
                dec_sym = bus.s_sym;
            end
            FLUSH: begin
                busy       = 1'b1;
                step       = ~stall & (step_cnt_q < MAX_STEPS);
                frame_done = frame_end;
            end
            default: ;
        endcase
    end

    assign bus.busy       = busy;
    assign bus.s_ready    = s_ready;
    assign bus.dec_clr    = dec_clr;
    assign bus.dec_en     = step;
    assign bus.dec_sym    = dec_sym;
    assign bus.m_valid    = m_valid;
    assign bus.m_bit      = bus.dec_bit;
    assign bus.m_last     = m_last;
    assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Bench for viterbi_frame_ctrl with a register-exchange K=3 decode core model.
module tb_viterbi_frame_ctrl;
    import viterbi_pkg::*;

    localparam int FRAME_LEN = 64;
    localparam int TAIL_LEN  = DEF_TAIL_LEN;
    localparam int TB_DEPTH  = DEF_TB_DEPTH;
    localparam int CNT_W     = 16;
    localparam int INFO      = FRAME_LEN - TAIL_LEN;

    logic clk;
    logic rst;
    viterbi_frame_ctrl_if bus();

    viterbi_frame_ctrl #(
        .FRAME_LEN (FRAME_LEN),
        .TAIL_LEN  (TAIL_LEN),
        .TB_DEPTH  (TB_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tot = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- decode core model ----------------
    int                  pm [4];
    logic [TB_DEPTH-1:0] pp [4];
    logic                core_bit = 1'b0;
    assign bus.dec_bit = core_bit;

    initial begin
        for (int s = 0; s < 4; s++) begin
            pm[s] = 0;
            pp[s] = '0;
        end
        forever begin : core_step
            int                  npm [4];
            logic [TB_DEPTH-1:0] npp [4];
            int                  bs;
            @(posedge clk);
            if (bus.dec_clr) begin
                for (int s = 0; s < 4; s++) begin
                    pm[s] = (s == 0) ? 0 : 64;
                    pp[s] = '0;
                end
            end else if (bus.dec_en) begin
                // state index = {u(t-1), u(t-2)}; next = {u, u(t-1)}
                for (int ns = 0; ns < 4; ns++) begin
                    logic u, a;
                    int   bestm, bp;
                    u = ns[1];
                    a = ns[0];
                    bestm = 0;
                    bp    = 0;
                    for (int b = 0; b < 2; b++) begin
                        logic       bb;
                        logic [1:0] es;
                        int         p, m;
                        bb = b[0];
                        p  = 2 * int'(a) + b;
                        es = {u ^ a ^ bb, u ^ bb};
                        m  = pm[p] + int'(es[1] != bus.dec_sym[1]) + int'(es[0] != bus.dec_sym[0]);
                        if (b == 0 || m < bestm) begin
                            bestm = m;
                            bp    = p;
                        end
                    end
                    npm[ns] = bestm;
                    npp[ns] = {pp[bp][TB_DEPTH-2:0], u};
                end
                for (int s = 0; s < 4; s++) begin
                    pm[s] = npm[s];
                    pp[s] = npp[s];
                end
            end
            bs = 0;
            for (int s = 1; s < 4; s++) if (pm[s] < pm[bs]) bs = s;
            core_bit = pp[bs][TB_DEPTH-1];
        end
    end

    // ---------------- sink ready driver ----------------
    bit rdy_toggle = 1'b0;
    initial begin
        int rc;
        rc = 0;
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_toggle) begin
                rc++;
                if (rc == 3) begin
                    rc = 0;
                    bus.m_ready = ~bus.m_ready;
                end
            end else begin
                bus.m_ready = 1'b1;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [1:0] sb [$];          // {last, bit}
    int   n_out, n_clr, n_done, first_mv, first_acc;
    bit   prev_stall = 1'b0;
    logic prev_bit   = 1'b0;

    initial forever begin
        logic [1:0] e;
        @(negedge clk);
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.dec_clr)    n_clr++;
            if (bus.frame_done) n_done++;
            if (bus.m_valid && first_mv < 0) first_mv = cyc;
            if (prev_stall) chk("hold_bit", bus.m_bit, prev_bit);
            if (bus.m_valid && !bus.m_ready) begin
                chk("stall_en", bus.dec_en, 0);
                chk("stall_rdy", bus.s_ready, 0);
            end
            if (bus.s_ready) begin
                chk("run_en", bus.dec_en, bus.s_valid);
                if (bus.s_valid) chk("run_sym", bus.dec_sym, bus.s_sym);
            end else if (bus.dec_en) begin
                chk("flush_sym", bus.dec_sym, 0);
            end
            if (bus.m_valid && bus.m_ready) begin
                chk("sb_avail", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("m_bit", bus.m_bit, e[0]);
                    chk("m_last", bus.m_last, e[1]);
                end
                n_out++;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_bit   = bus.m_bit;
        end
    end

    // ---------------- stimulus ----------------
    logic [63:0] pat;
    logic [1:0]  syms [FRAME_LEN];

    task automatic build(input logic [63:0] p);
        logic u, b1, b2;
        pat = p;
        b1 = 1'b0;
        b2 = 1'b0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            u = (i < INFO) ? pat[i] : 1'b0;
            syms[i] = {u ^ b1 ^ b2, u ^ b2};
            b2 = b1;
            b1 = u;
        end
    endtask

    // Called at posedge+1; pulses start for one cycle
    task automatic start_frame();
        n_out = 0; n_clr = 0; n_done = 0; first_mv = -1; first_acc = -1;
        bus.start = 1'b1;
        @(negedge clk);
        chk("idle_gap", {bus.busy, bus.frame_done}, 2'b00);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Drive symbols [from,to); flip c1 of flip_at; 5-cycle gap after every gap_every symbols
    task automatic drive(input int from, input int to, input int flip_at, input int gap_every);
        for (int i = from; i < to; i++) begin
            logic [1:0] s;
            int w;
            s = syms[i];
            if (i == flip_at) s[1] = ~s[1];
            bus.s_valid = 1'b1;
            bus.s_sym   = s;
            w = 0;
            forever begin
                @(negedge clk);
                if (bus.s_ready) break;
                w++;
                if (w > 500) begin
                    chk("acc_timeout", w, 0);
                    bus.s_valid = 1'b0;
                    return;
                end
                @(posedge clk); #1;
            end
            if (first_acc < 0) first_acc = cyc;
            if (i < INFO) sb.push_back({i == INFO - 1, pat[i]});
            @(posedge clk); #1;
            bus.s_valid = 1'b0;
            if (gap_every > 0 && (i % gap_every) == gap_every - 1 && i < FRAME_LEN - 1) begin
                repeat (5) begin
                    @(negedge clk);
                    chk("gap_en", bus.dec_en, 0);
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    // Wait for frame_done, then check frame totals; returns at posedge+1
    task automatic wait_done(input int exp_lat);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.frame_done && w < 3000);
        chk("done_seen", bus.frame_done, 1);
        @(posedge clk); #1;
        chk("n_out", n_out, INFO);
        chk("sb_left", sb.size(), 0);
        chk("n_clr", n_clr, 1);
        chk("n_done", n_done, 1);
        if (exp_lat > 0) chk("latency", first_mv - first_acc + 1, exp_lat);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_sym = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {bus.busy, bus.s_ready, bus.dec_clr, bus.dec_en, bus.m_valid,
                         bus.m_last, bus.frame_done, bus.dec_sym}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // T1: clean frame, full throughput
        build(64'h1B3D_96E5_C0A7_4F28);
        start_frame();
        drive(0, FRAME_LEN, -1, 0);
        wait_done(TB_DEPTH + 1);

        // T2: single channel error in symbol 20
        repeat (3) @(posedge clk);
        #1;
        start_frame();
        drive(0, FRAME_LEN, 19, 0);
        wait_done(0);

        // T3: sink back-pressure
        rdy_toggle = 1'b1;
        start_frame();
        drive(0, FRAME_LEN, -1, 0);
        wait_done(0);
        rdy_toggle = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // T4: source gaps
        start_frame();
        drive(0, FRAME_LEN, -1, 7);
        wait_done(0);

        // T5: start re-pulse ignored, then reset mid-frame, then fresh frame
        start_frame();
        drive(0, 10, -1, 0);
        bus.start = 1'b1;
        @(negedge clk);
        chk("busy_hold", bus.busy, 1);
        chk("no_reclr", bus.dec_clr, 0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("no_reclr2", bus.dec_clr, 0);
        @(posedge clk); #1;
        drive(10, 30, -1, 0);
        chk("n_clr_mid", n_clr, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid", {bus.busy, bus.s_ready, bus.dec_clr, bus.dec_en, bus.m_valid,
                        bus.m_last, bus.frame_done, bus.dec_sym}, 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        build({$urandom, $urandom});
        start_frame();
        drive(0, FRAME_LEN, -1, 0);
        wait_done(TB_DEPTH + 1);

        // T6: back-to-back frames, start in the cycle after frame_done
        build(64'hF0E1_D2C3_B4A5_9687);
        start_frame();
        drive(0, FRAME_LEN, -1, 0);
        wait_done(TB_DEPTH + 1);
        build({$urandom, $urandom});
        start_frame();
        drive(0, FRAME_LEN, -1, 0);
        wait_done(TB_DEPTH + 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
